// File: rtl/fft_twiddle_sequencer_if.sv
// Sample stream, twiddle ROM and multiplier-side signals
// of one radix-2 SDF twiddle stage.
interface fft_twiddle_sequencer_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int TWIDDLE_WIDTH = 32,
  parameter int LOG2_N        = 10
);
  logic                       in_valid;
  logic                       in_sof;
  logic [DATA_WIDTH-1:0]      in_data;
  logic [LOG2_N-2:0]          rom_addr;
  logic [TWIDDLE_WIDTH-1:0]   rom_data;
  logic [DATA_WIDTH/2-1:0]    mul_in_real;
  logic [DATA_WIDTH/2-1:0]    mul_in_imag;
  logic [TWIDDLE_WIDTH/2-1:0] mul_tw_real;
  logic [TWIDDLE_WIDTH/2-1:0] mul_tw_imag;
  logic                       out_valid;
  logic                       out_bypass;
  logic                       out_sof;
  logic                       out_eof;
  logic [DATA_WIDTH-1:0]      bypass_data;

  modport master (
    output in_valid, in_sof, in_data, rom_data,
    input  rom_addr, mul_in_real, mul_in_imag,
    input  mul_tw_real, mul_tw_imag,
    input  out_valid, out_bypass, out_sof, out_eof,
    input  bypass_data
  );

  modport slave (
    input  in_valid, in_sof, in_data, rom_data,
    output rom_addr, mul_in_real, mul_in_imag,
    output mul_tw_real, mul_tw_imag,
    output out_valid, out_bypass, out_sof, out_eof,
    output bypass_data
  );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Twiddle address sequencing and sample/flag alignment
// for the complex multiplier of one radix-2 SDF DIF stage.
module fft_twiddle_sequencer #(
  parameter int DATA_WIDTH    = 64,
  parameter int TWIDDLE_WIDTH = 32,
  parameter int LOG2_N        = 10,
  parameter int STAGE         = 0,
  parameter int MULT_LATENCY  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_twiddle_sequencer_if.slave bus
);

  localparam int HW    = DATA_WIDTH / 2;
  localparam int TH    = TWIDDLE_WIDTH / 2;
  localparam int AW    = LOG2_N - 1;
  localparam int HB    = LOG2_N - STAGE - 1;
  localparam int DEPTH = 1 + MULT_LATENCY;

  localparam logic [LOG2_N-1:0] OFF_MASK =
    LOG2_N'((1 << HB) - 1);

  typedef struct packed {
    logic                  valid;
    logic                  bypass;
    logic                  sof;
    logic                  eof;
    logic [DATA_WIDTH-1:0] data;
  } pipe_t;

  logic [LOG2_N-1:0]     r_idx;
  logic [AW-1:0]         r_rom_addr;
  logic [HW-1:0]         r_mul_re;
  logic [HW-1:0]         r_mul_im;
  logic                  r_tw_en;
  pipe_t                 r_pipe [DEPTH];
  logic                  r_out_valid;
  logic                  r_out_bypass;
  logic                  r_out_sof;
  logic                  r_out_eof;
  logic [DATA_WIDTH-1:0] r_byp_data;

  logic [LOG2_N-1:0]     w_idx;
  logic [LOG2_N-1:0]     w_off;
  logic [AW-1:0]         w_off_sh;
  logic [AW-1:0]         w_addr;
  logic                  w_bypass;
  logic                  w_sof;
  logic                  w_eof;
  pipe_t                 w_in;

  // Lower half of each M-block multiplies by 1, upper half
  // reads W_N^((n-M/2)*2^STAGE) from the ROM.
  always_comb begin
    w_idx    = bus.in_sof ? '0 : r_idx;
    w_off    = w_idx & OFF_MASK;
    w_off_sh = AW'(w_off << STAGE);
    w_bypass = ~w_idx[HB];
    w_addr   = w_bypass ? '0 : w_off_sh;
    w_sof    = (w_idx == '0);
    w_eof    = &w_idx;
    w_in.valid  = bus.in_valid;
    w_in.bypass = bus.in_valid & w_bypass;
    w_in.sof    = bus.in_valid & w_sof;
    w_in.eof    = bus.in_valid & w_eof;
    w_in.data   = bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_rom_addr   <= '0;
      r_mul_re     <= '0;
      r_mul_im     <= '0;
      r_tw_en      <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        r_pipe[k] <= '0;
      end
      r_out_valid  <= 1'b0;
      r_out_bypass <= 1'b0;
      r_out_sof    <= 1'b0;
      r_out_eof    <= 1'b0;
      r_byp_data   <= '0;
    end else begin
      if (bus.in_valid) begin
        r_idx      <= w_idx + 1'b1;
        r_rom_addr <= w_addr;
      end
      r_pipe[0] <= w_in;
      for (int k = 1; k < DEPTH; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
      // Sample meets its ROM word one cycle after the address.
      if (r_pipe[0].valid) begin
        r_mul_re <= r_pipe[0].data[DATA_WIDTH-1:HW];
        r_mul_im <= r_pipe[0].data[HW-1:0];
        r_tw_en  <= 1'b1;
      end
      r_out_valid  <= r_pipe[DEPTH-1].valid;
      r_out_bypass <= r_pipe[DEPTH-1].bypass;
      r_out_sof    <= r_pipe[DEPTH-1].sof;
      r_out_eof    <= r_pipe[DEPTH-1].eof;
      r_byp_data   <= r_pipe[DEPTH-1].data;
    end
  end

  assign bus.rom_addr    = r_rom_addr;
  assign bus.mul_in_real = r_mul_re;
  assign bus.mul_in_imag = r_mul_im;
  // ROM output is the registered word; masked until a sample lands.
  assign bus.mul_tw_real =
    r_tw_en ? bus.rom_data[TWIDDLE_WIDTH-1:TH] : '0;
  assign bus.mul_tw_imag =
    r_tw_en ? bus.rom_data[TH-1:0] : '0;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_bypass  = r_out_bypass;
  assign bus.out_sof     = r_out_sof;
  assign bus.out_eof     = r_out_eof;
  assign bus.bypass_data = r_byp_data;

endmodule

// File: doc/fft_twiddle_sequencer.md
Name: fft_twiddle_sequencer

Overview:
- Feeds the 3-cycle complex twiddle multiplier in one radix-2 single-path-delay-feedback (SDF) decimation-in-frequency FFT stage.
- Tracks the sample index within each frame and drives the address of an external twiddle ROM (1-cycle read latency).
- Presents each sample to the multiplier aligned with its ROM twiddle.
- Generates a valid/bypass/frame-marker pipeline, plus a delayed copy of the data, both aligned with the multiplier output.

Parameters:
- DATA_WIDTH, 64, packed complex sample width: {real, imag}, each DATA_WIDTH/2 bits, signed.
- TWIDDLE_WIDTH, 32, packed ROM word width: {real, imag}, Q1.15 each.
- LOG2_N, 10, log2 of FFT frame size N.
- STAGE, 0, stage index, range 0..LOG2_N-1.
- MULT_LATENCY, 3, latency of the downstream multiplier in cycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample present this cycle; no backpressure
- in_sof  in  1  first sample of frame; qualified by in_valid
- in_data  in  DATA_WIDTH  {real, imag} sample
- rom_addr  out  LOG2_N-1  twiddle ROM address, registered
- rom_data  in  TWIDDLE_WIDTH  ROM word, valid 1 cycle after rom_addr
- mul_in_real  out  DATA_WIDTH/2  to multiplier in_real
- mul_in_imag  out  DATA_WIDTH/2  to multiplier in_imag
- mul_tw_real  out  TWIDDLE_WIDTH/2  to multiplier twiddle_real
- mul_tw_imag  out  TWIDDLE_WIDTH/2  to multiplier twiddle_imag
- out_valid  out  1  multiplier output valid this cycle
- out_bypass  out  1  use bypass_data instead of the multiplier output (twiddle = 1)
- out_sof  out  1  frame start, aligned with out_valid
- out_eof  out  1  frame end, aligned with out_valid
- bypass_data  out  DATA_WIDTH  input sample delayed to align with the multiplier output

Behaviour:
- Reset (asynchronous, rst_n low):
  - Sample counter cleared to 0.
  - rom_addr = 0, all mul_* outputs = 0.
  - out_valid, out_bypass, out_sof, out_eof = 0; bypass_data = 0.
  - Every stage of the valid pipeline cleared.
  - Reset mid-frame discards all in-flight samples; no out_valid follows reset until new input arrives.
- Counter idx (LOG2_N bits):
  - Increments on each in_valid.
  - in_valid with in_sof forces the current sample to idx = 0, so resync is allowed mid-frame; the next sample is idx = 1.
  - Wraps N-1 -> 0 without needing in_sof.
  - Before the first in_sof after reset, counting starts from 0.
- Twiddle selection: M = N >> STAGE; n = idx mod M.
  - n < M/2: bypass = 1, rom_addr = 0.
  - n >= M/2: bypass = 0, rom_addr = (n - M/2) << STAGE.
  - For STAGE = LOG2_N-1, every sample uses address 0; the bypass rule still applies.
- Cycle alignment, input accepted at edge E0:
  - E0: rom_addr registered; in_data and flags captured into stage-1 registers.
  - E1: mul_in_* = sample, mul_tw_* = rom_data.
  - E1+MULT_LATENCY: out_valid = 1, with out_bypass, out_sof, out_eof and bypass_data for that sample. Total latency from input edge is 1+MULT_LATENCY = 4 cycles.
- Flags:
  - out_sof marks the idx = 0 sample.
  - out_eof marks the idx = N-1 sample.
- Pipeline behaviour:
  - Flags and bypass_data are carried through a (1+MULT_LATENCY)-deep shift register, enabled every cycle.
  - Gaps in in_valid propagate unchanged as out_valid = 0 bubbles.
- Idle cycles (in_valid = 0): mul_in_* and mul_tw_* hold their previous values, counter and rom_addr hold, out_valid = 0.
- Back-to-back valids: one sample per cycle; no throughput limit.
- Bypass path: the multiplier result is ignored when out_bypass = 1. This avoids the gain error of a non-representable +1.0 in Q1.15.
- Arithmetic: none in the data path; pure alignment. Address arithmetic is unsigned, truncated to LOG2_N-1 bits.

Test Plan:
- LOG2_N=4, STAGE=1; 16 back-to-back valids starting with in_sof -> rom_addr sequence is 0,0,0,0,0,2,4,6 twice. out_bypass is 1 for idx 0-3 and 8-11. out_valid first rises 4 cycles after the first input edge. out_sof on idx 0, out_eof on idx 15.
- Same configuration, ROM model returning addr-dependent words (e.g. {addr, ~addr}) -> on each cycle mul_tw_* matches the word for the sample on mul_in_*.
- Same configuration, in_valid toggling 1,0,1,0 with data 0x1 .. 0x8 -> out_valid reproduces the same gap pattern 4 cycles later. bypass_data = 0x1 .. 0x8 in order; idx advances only on valid cycles.
- in_sof asserted at idx 5 mid-frame -> that sample gets idx 0 (bypass=1, out_sof=1 four cycles later); the next sample gets idx 1.
- rst_n pulsed low with 3 samples in flight -> all outputs read 0 immediately (asynchronous); no out_valid is produced after release; the next in_valid starts at idx 0.
- LOG2_N=4, STAGE=3 -> rom_addr constant 0; out_bypass alternates 1,0 per sample; 17th sample wraps to idx 0 without in_sof and out_sof=1.
